// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD dispatcher slice: defaults, FSM encoding, FIFO entry layout.
package gcd_pkg;

  localparam int unsigned GCD_W       = 8;
  localparam int unsigned GCD_DEPTH   = 4;
  localparam int unsigned GCD_TAG_W   = 4;
  localparam int unsigned GCD_TIMEOUT = 300;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE
  } gcd_state_t;

  // Entry layout at default widths; the dispatcher packs {a, b, tag} in this order.
  typedef struct packed {
    logic [GCD_W-1:0]     a;
    logic [GCD_W-1:0]     b;
    logic [GCD_TAG_W-1:0] tag;
  } gcd_entry_t;

endpackage

// File: rtl/gcd_dispatcher_if.sv
// Bundles the operand, result, core and status signals of the GCD dispatcher.
interface gcd_dispatcher_if
  import gcd_pkg::*;
#(
    parameter int unsigned W     = GCD_W,
    parameter int unsigned TAG_W = GCD_TAG_W
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_gcd;
    logic [TAG_W-1:0] out_tag;
    logic             gcd_start;
    logic [W-1:0]     gcd_a;
    logic [W-1:0]     gcd_b;
    logic             gcd_done;
    logic [W-1:0]     gcd_result;
    logic             busy;
    logic             timeout_err;

    modport master (
        input  in_valid, in_a, in_b, out_ready, gcd_done, gcd_result,
        output in_ready, out_valid, out_gcd, out_tag, gcd_start, gcd_a, gcd_b,
               busy, timeout_err
    );

    modport slave (
        output in_valid, in_a, in_b, out_ready, gcd_done, gcd_result,
        input  in_ready, out_valid, out_gcd, out_tag, gcd_start, gcd_a, gcd_b,
               busy, timeout_err
    );
endinterface

// File: rtl/gcd_op_fifo.sv
// Synchronous operand FIFO with wrap-around pointers; no full or empty bypass.
module gcd_op_fifo #(
    parameter  int unsigned DW    = 20,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
endmodule

// File: rtl/gcd_dispatcher.sv
// Queues operand pairs, issues them one at a time to a start/done GCD core,
// and holds each tagged result for a valid/ready consumer.
module gcd_dispatcher
  import gcd_pkg::*;
#(
    parameter int unsigned W       = GCD_W,
    parameter int unsigned DEPTH   = GCD_DEPTH,
    parameter int unsigned TAG_W   = GCD_TAG_W,
    parameter int unsigned TIMEOUT = GCD_TIMEOUT
) (
    input logic clk,
    input logic rst_n,
    gcd_dispatcher_if.master bus
);
    localparam int unsigned EW = 2 * W + TAG_W;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(TIMEOUT);

    gcd_state_t       state, state_nxt;
    logic [TAG_W-1:0] tag_cnt;
    logic [W-1:0]     op_a, op_b;
    logic [TAG_W-1:0] op_tag;
    logic             out_valid_q;
    logic [W-1:0]     out_gcd_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [CW-1:0]    to_cnt;
    logic             timeout_q;
    logic             capture;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [AW:0]      fifo_count;
    logic [EW-1:0]    fifo_din, fifo_dout;

    assign fifo_push = bus.in_valid && !fifo_full;
    assign fifo_din  = {bus.in_a, bus.in_b, tag_cnt};

    gcd_op_fifo #(.DW(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // A held result blocks issue unless it is being consumed this cycle.
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        capture   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty && (!out_valid_q || bus.out_ready)) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (bus.gcd_done) begin
                    capture   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_cnt     <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_tag      <= '0;
            out_valid_q <= 1'b0;
            out_gcd_q   <= '0;
            out_tag_q   <= '0;
            to_cnt      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (fifo_push) tag_cnt <= tag_cnt + 1'b1;
            if (fifo_pop) {op_a, op_b, op_tag} <= fifo_dout;

            if (capture) begin
                out_valid_q <= 1'b1;
                out_gcd_q   <= bus.gcd_result;
                out_tag_q   <= op_tag;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            // Counter saturates at TIMEOUT-1 so the flag cannot be re-armed by wrap.
            if (state == ST_ISSUE)
                to_cnt <= '0;
            else if (state == ST_WAIT_DONE && to_cnt != CW'(TIMEOUT - 1))
                to_cnt <= to_cnt + 1'b1;

            if (state == ST_WAIT_DONE && !bus.gcd_done && to_cnt == CW'(TIMEOUT - 1))
                timeout_q <= 1'b1;
        end
    end

    assign bus.in_ready    = !fifo_full;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_gcd     = out_gcd_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.gcd_start   = (state == ST_ISSUE);
    assign bus.gcd_a       = op_a;
    assign bus.gcd_b       = op_b;
    assign bus.busy        = (state != ST_IDLE) || (fifo_count != '0);
    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_gcd_dispatcher.sv
// Randomized bench for gcd_dispatcher with a behavioural GCD core and an in-order scoreboard.
module tb_gcd_dispatcher;
    localparam int unsigned W = 8, DEPTH = 4, TAG_W = 4, TIMEOUT = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gcd_dispatcher_if #(.W(W), .TAG_W(TAG_W)) bus ();

    gcd_dispatcher #(.W(W), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0, n_fail = 0;
    int cyc = 0, start_cyc = 0, n_start = 0, n_out = 0;
    int unsigned tag_m = 0;
    logic prev_start = 1'b0;
    logic [7:0] exp_gcd[$], exp_tag[$], iss_a[$], iss_b[$];

    function automatic int unsigned gcd_ref(input int unsigned a, input int unsigned b);
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural core: latches operands on start, pulses done core_lat cycles later.
    int unsigned core_lat = 3;
    int unsigned core_cnt;
    logic [7:0]  core_res;
    always @(posedge clk) begin
        if (!rst_n) begin
            core_cnt       <= 0;
            bus.gcd_done   <= 1'b0;
            bus.gcd_result <= '0;
        end else begin
            bus.gcd_done <= 1'b0;
            if (bus.gcd_start) begin
                core_cnt <= core_lat;
                core_res <= 8'(gcd_ref(bus.gcd_a, bus.gcd_b));
            end else if (core_cnt != 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1) begin
                    bus.gcd_done   <= 1'b1;
                    bus.gcd_result <= core_res;
                end
            end
        end
    end

    // Called at a negedge with inputs already driven; records handshakes, advances one cycle.
    task automatic step();
        if (rst_n && bus.in_valid && bus.in_ready) begin
            exp_gcd.push_back(8'(gcd_ref(bus.in_a, bus.in_b)));
            exp_tag.push_back(8'(tag_m % (1 << TAG_W)));
            iss_a.push_back(bus.in_a);
            iss_b.push_back(bus.in_b);
            tag_m++;
        end
        if (rst_n && bus.gcd_start) begin
            check("start_gap", 32'(prev_start), 0);
            if (iss_a.size() == 0) check("spurious_start", 1, 0);
            else begin
                check("issue_a", 32'(bus.gcd_a), 32'(iss_a.pop_front()));
                check("issue_b", 32'(bus.gcd_b), 32'(iss_b.pop_front()));
            end
            start_cyc = cyc;
            n_start++;
        end
        prev_start = bus.gcd_start;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_gcd.size() == 0) check("spurious_out", 1, 0);
            else begin
                check("out_gcd", 32'(bus.out_gcd), 32'(exp_gcd.pop_front()));
                check("out_tag", 32'(bus.out_tag), 32'(exp_tag.pop_front()));
            end
            n_out++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = bus.in_ready;
            step();
        end
        if (!acc) check("push_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (exp_gcd.size() == 0 && !bus.busy && !bus.out_valid) break;
            step();
        end
        check("drain_left", exp_gcd.size(), 0);
    endtask

    task automatic wait_out_valid(input string tag);
        int i;
        for (i = 0; i < 600 && !bus.out_valid; i++) step();
        check(tag, 32'(bus.out_valid), 1);
    endtask

    task automatic check_reset_vals();
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_gcd", 32'(bus.out_gcd), 0);
        check("rst_out_tag", 32'(bus.out_tag), 0);
        check("rst_start", 32'(bus.gcd_start), 0);
        check("rst_gcd_a", 32'(bus.gcd_a), 0);
        check("rst_gcd_b", 32'(bus.gcd_b), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_timeout", 32'(bus.timeout_err), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
    endtask

    initial begin
        int acc, s0, o0, d;
        logic [7:0] g, t;
        logic a_acc;

        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;

        // Single job (12,8)
        core_lat = $urandom_range(1, 10);
        bus.out_ready = 1'b1;
        s0 = n_start;
        push(8'd12, 8'd8);
        wait_out_valid("t1_out_valid");
        step();
        check("t1_ov_one_cycle", 32'(bus.out_valid), 0);
        check("t1_starts", n_start - s0, 1);
        step();
        check("t1_busy_idle", 32'(bus.busy), 0);

        // Zero operands and extremes
        push(8'd0, 8'd9);
        push(8'd0, 8'd0);
        push(8'd255, 8'd1);
        drain();
        check("t2_no_timeout", 32'(bus.timeout_err), 0);

        // Result held: one in flight plus DEPTH queued, then in_ready drops
        bus.out_ready = 1'b0;
        s0 = n_start;
        o0 = n_out;
        acc = 0;
        bus.in_a = 8'($urandom);
        bus.in_b = 8'($urandom);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a_acc = bus.in_ready;
            step();
            if (a_acc) begin
                acc++;
                bus.in_a = 8'($urandom);
                bus.in_b = 8'($urandom);
            end
        end
        bus.in_valid = 1'b0;
        check("t3_accepted", acc, DEPTH + 1);
        check("t3_in_ready", 32'(bus.in_ready), 0);
        check("t3_one_start", n_start - s0, 1);
        check("t3_held", 32'(bus.out_valid), 1);
        drain();
        check("t3_drained", n_out - o0, DEPTH + 1);

        // Backpressure on the result with a job waiting behind it
        bus.out_ready = 1'b0;
        push(8'($urandom), 8'($urandom));
        push(8'($urandom), 8'($urandom));
        wait_out_valid("t4_out_valid");
        g = bus.out_gcd;
        t = bus.out_tag;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t4_gcd_stable", 32'(bus.out_gcd), 32'(g));
            check("t4_tag_stable", 32'(bus.out_tag), 32'(t));
            check("t4_no_start", 32'(bus.gcd_start), 0);
        end
        bus.out_ready = 1'b1;
        step();
        check("t4_reissue", 32'(bus.gcd_start), 1);
        drain();

        // Random traffic with random core latency and consumer stalls
        for (int i = 0; i < 700; i++) begin
            if (!bus.in_valid) begin
                bus.in_valid = ($urandom_range(0, 2) != 0);
                bus.in_a = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
                bus.in_b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            core_lat = $urandom_range(1, 12);
            a_acc = bus.in_valid && bus.in_ready;
            step();
            if (a_acc) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        drain();
        check("rand_no_timeout", 32'(bus.timeout_err), 0);

        // Slow core: timeout flag after TIMEOUT cycles in WAIT_DONE, job still completes
        core_lat = 400;
        bus.out_ready = 1'b1;
        s0 = n_start;
        push(8'd36, 8'd24);
        for (int i = 0; i < 20 && n_start == s0; i++) step();
        check("to_started", n_start - s0, 1);
        for (int i = 0; i < 310; i++) begin
            d = cyc - start_cyc;
            if (d == TIMEOUT) check("to_before", 32'(bus.timeout_err), 0);
            if (d == TIMEOUT + 1) check("to_rise", 32'(bus.timeout_err), 1);
            step();
        end
        core_lat = 4;
        o0 = n_out;
        for (int i = 0; i < 200 && n_out == o0; i++) step();
        check("to_late_result", n_out - o0, 1);
        push(8'd49, 8'd14);
        drain();
        check("to_sticky", 32'(bus.timeout_err), 1);

        // Reset while a job is in flight with three queued behind it
        core_lat = 50;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'($urandom), 8'($urandom));
        check("t6_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        step();
        check_reset_vals();
        exp_gcd.delete();
        exp_tag.delete();
        iss_a.delete();
        iss_b.delete();
        tag_m = 0;
        rst_n = 1'b1;
        o0 = n_out;
        s0 = n_start;
        for (int i = 0; i < 80; i++) step();
        check("t6_no_stale_out", n_out - o0, 0);
        check("t6_no_stale_start", n_start - s0, 0);
        core_lat = 3;
        push(8'd21, 8'd14);
        drain();
        check("t6_one_result", n_out - o0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gcd_dispatcher.md
Name: gcd_dispatcher

Overview:
Initiator-side front end for the team's start/done GCD core: it queues operand pairs from an upstream valid/ready source and issues them one at a time to the core. It captures each one-cycle done/result pulse and holds it for a downstream valid/ready consumer.
Each result carries a sequence tag. A sticky timeout flag reports a core that fails to respond in time. It sits between the operand producer (e.g. a keypad/UART parser) and the GCD core instance.

Parameters:
W, 8, operand/result width (matches the core)
DEPTH, 4, operand FIFO entries (power of 2, >=2)
TAG_W, 4, sequence tag width
TIMEOUT, 300, cycles in WAIT_DONE before timeout_err sets (must exceed worst-case core latency, 2^W+4)

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept
in_a  in  W  operand a
in_b  in  W  operand b
out_valid  out  1  result held
out_ready  in  1  consumer accepts result
out_gcd  out  W  result
out_tag  out  TAG_W  tag of the job that produced out_gcd
gcd_start  out  1  start pulse to core
gcd_a  out  W  operand a to core
gcd_b  out  W  operand b to core
gcd_done  in  1  core done pulse
gcd_result  in  W  core result, valid when gcd_done=1
busy  out  1  job in flight or FIFO non-empty
timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk. After the reset edge: FIFO empty, tag counter 0, state IDLE. Outputs: out_valid=0, out_gcd=0, out_tag=0, gcd_start=0, gcd_a=0, gcd_b=0, busy=0, timeout_err=0, in_ready=1.
- Reset mid-operation: flushes the FIFO, drops the in-flight job and clears any held result. The core shares rst_n, so both ends return to idle together.
- Input side: in_ready = !full, combinational from the FIFO count. A push occurs when in_valid && in_ready. The entry stores {a, b, tag}, and the tag counter then increments, wrapping 2^TAG_W-1 -> 0.
- When full, in_ready=0 even if a pop occurs in the same cycle (no full-bypass). There is no empty-bypass: a pushed entry is poppable from the next cycle.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE: if FIFO non-empty && (!out_valid || out_ready), pop the head into the op registers {a, b, tag} and go to ISSUE. Otherwise stay.
- ISSUE: exactly one cycle. gcd_start=1, gcd_a/gcd_b = op registers. The core latches its operands at the end of this cycle. Next state WAIT_DONE; the timeout counter clears.
- WAIT_DONE: gcd_start=0, and gcd_a/gcd_b hold their values.
  - Counter increments each cycle.
  - On gcd_done=1: out_gcd <= gcd_result, out_tag <= op tag, out_valid <= 1, next state IDLE. out_valid is therefore high in the cycle after done.
  - When the counter reaches TIMEOUT-1 with no done, timeout_err <= 1. The flag is sticky until reset. The FSM keeps waiting, and a later done completes the job normally.
- gcd_done outside WAIT_DONE is ignored.
- Output side: out_valid stays high, with out_gcd/out_tag stable, until out_ready=1 at a clock edge, then clears unless a new capture occurs on that edge.
  - A capture can coincide with a consume only via the IDLE issue rule, which permits issue when out_ready=1. Otherwise the FSM cannot reach capture while out_valid=1.
  - A capture always wins: out_valid remains 1 with new data.
- gcd_start is never high in two consecutive cycles. There is at most one job in flight.
- busy = (state != IDLE) || FIFO non-empty.
- Operand values are passed through unmodified; zero operands are legal (core returns the non-zero operand, or 0 for 0,0).

Decomposition:
- Package gcd_pkg: FSM state encoding (IDLE/ISSUE/WAIT_DONE), default W, TAG_W, DEPTH, TIMEOUT, and the FIFO entry struct {a, b, tag}.
- Sub-module gcd_op_fifo: synchronous FIFO with DEPTH entries of width 2W+TAG_W, ports push/pop/full/empty, count with wrap-around pointers.
- The FSM, output register and timeout counter stay in gcd_dispatcher.

Test Plan:
1. With the real GCD core attached, push (12,8) once, out_ready=1 -> gcd_start pulses for exactly 1 cycle with gcd_a=12, gcd_b=8; out_gcd=4, out_tag=0, out_valid high 1 cycle; busy returns to 0.
2. Push (0,9), then (0,0), then (255,1) -> results 9, 0, 1 in order with tags 0, 1, 2; no timeout_err.
3. out_ready=0, present 8 jobs back-to-back -> job 0 issued and its result held; exactly 5 accepted (1 in flight + DEPTH), then in_ready=0. No further gcd_start while held. Releasing out_ready drains tags 0..4 in order, one result per job.
4. Result backpressure: hold out_ready=0 for 10 cycles after out_valid rises -> out_gcd/out_tag stable and gcd_start stays 0. Raise out_ready -> the next queued job issues in that same cycle's transition.
5. Stub core that asserts done after 400 cycles, TIMEOUT=300 -> timeout_err rises 300 cycles after entering WAIT_DONE and stays 1. The later done still delivers the result, and the next job proceeds.
6. Reset mid-job: assert rst_n=0 for 1 cycle while in WAIT_DONE with 3 jobs queued -> all outputs at reset values. No result for the dropped jobs appears; the next push gets tag 0.
